// File: rtl/gb_result_reader.sv
`default_nettype none
// ============================================================================
// Module  : gb_result_reader
// Brief   : Drains the output-feature region of the global buffer to the host
//           as a stream of full-width lines over valid/ready.
// Rev     : 1.0
// ============================================================================
module gb_result_reader #(
    parameter int DATA_WIDTH            = 8,
    parameter int length                = 16,
    parameter int global_buf_addr_width = 17,
    parameter int FIFO_DEPTH            = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [global_buf_addr_width-1:0]     base_addr,
    input  logic [global_buf_addr_width:0]       n_lines,
    output logic                                 gb_ren,
    output logic [global_buf_addr_width-1:0]     gb_raddr,
    input  logic [DATA_WIDTH*length-1:0]         gb_dout,
    output logic [DATA_WIDTH*length-1:0]         out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done
);

    localparam int c_AW = global_buf_addr_width;
    localparam int c_LW = DATA_WIDTH * length;
    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = c_PW + 1;

    localparam logic [c_AW:0]   c_ONE   = (c_AW+1)'(1);
    localparam logic [c_PW-1:0] c_PONE  = c_PW'(1);
    localparam logic [c_CW-1:0] c_CONE  = c_CW'(1);
    localparam logic [c_CW:0]   c_DEPTH = (c_CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_AW-1:0]   r_base;
    logic [c_AW:0]     r_nlines;
    logic [c_AW:0]     r_issued;
    logic [c_AW:0]     r_sent;
    logic [c_LW-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;
    logic              r_inflight;

    logic              w_pop;
    logic              w_credit;
    logic [c_AW:0]     w_last_idx;

    assign w_last_idx = r_nlines - c_ONE;
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;

    // A read may issue only if the line it returns is guaranteed a FIFO slot,
    // counting the read already in flight and the slot freed by this cycle's pop.
    assign w_credit = ({1'b0, r_count} + {{c_CW{1'b0}}, r_inflight})
                      < (c_DEPTH + {{c_CW{1'b0}}, w_pop});

    assign gb_ren   = (r_state == S_RUN) && (r_issued < r_nlines) && w_credit;
    assign gb_raddr = r_base + r_issued[c_AW-1:0];
    assign out_data = out_valid ? r_mem[r_rptr] : '0;
    assign out_last = out_valid && (r_sent == w_last_idx);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_FINISH);

    always_ff @(posedge clk) begin
        if (r_inflight) begin
            r_mem[r_wptr] <= gb_dout;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_nlines   <= '0;
            r_issued   <= '0;
            r_sent     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_nlines   <= n_lines;
                        r_issued   <= '0;
                        r_sent     <= '0;
                        r_wptr     <= '0;
                        r_rptr     <= '0;
                        r_count    <= '0;
                        r_inflight <= 1'b0;
                        r_state    <= (n_lines == '0) ? S_FINISH : S_RUN;
                    end
                end
                S_RUN: begin
                    r_inflight <= gb_ren;
                    if (gb_ren) begin
                        r_issued <= r_issued + c_ONE;
                    end
                    if (r_inflight) begin
                        r_wptr <= r_wptr + c_PONE;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + c_PONE;
                        r_sent <= r_sent + c_ONE;
                        if (r_sent == w_last_idx) begin
                            r_state <= S_FINISH;
                        end
                    end
                    case ({r_inflight, w_pop})
                        2'b10:   r_count <= r_count + c_CONE;
                        2'b01:   r_count <= r_count - c_CONE;
                        default: r_count <= r_count;
                    endcase
                end
                S_FINISH: begin
                    r_inflight <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/gb_result_reader.md
# gb_result_reader

Result readback engine for the point-cloud accelerator. After the top-level controller signals `done`, this block reads the output-feature region of the global buffer line by line through a free read port. It streams each 128-bit line to the host over a valid/ready interface. It is the drain-side counterpart of the external load path that writes input, weight and NIT data into the buffers.

## Interface
Parameters:
- `DATA_WIDTH`, 8, element width in bits
- `length`, 16, elements per global-buffer line; line width `LW = DATA_WIDTH*length` (128)
- `global_buf_addr_width`, 17, global-buffer address width `AW`
- `FIFO_DEPTH`, 2, prefetch FIFO entries (≥2; power of two)

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse, begins a readback; sampled only in IDLE
- `base_addr` in AW: first line address (normally `INIT_OUTPUT_ADDR`); latched on accepted `start`
- `n_lines` in AW+1: number of lines to read; latched on accepted `start`
- `gb_ren` out 1: global-buffer read enable
- `gb_raddr` out AW: global-buffer read address
- `gb_dout` in LW: global-buffer read data, valid exactly 1 cycle after `gb_ren`
- `out_data` out LW: streamed line
- `out_valid` out 1: `out_data` holds a valid line
- `out_ready` in 1: host accepts the beat when `out_valid && out_ready`
- `out_last` out 1: high with the final beat
- `busy` out 1: high from the cycle after an accepted `start` until `done`
- `done` out 1: one-cycle completion pulse

## Operation
- FSM states and transitions:
  - IDLE: waits for `start`; on `start`, goes to RUN (or FINISH if `n_lines==0`); latches `base_addr`/`n_lines`; clears `issued`, `sent` and the FIFO.
  - RUN: issues reads and drains the FIFO; goes to FINISH on the handshake of beat `n_lines-1`.
  - FINISH: holds for one cycle with `done=1`, `busy=0`, then returns to IDLE.
- Read issue:
  - In RUN, `gb_ren=1` when `issued < n_lines` and `fifo_count + inflight - pop < FIFO_DEPTH`.
  - `pop` is the current-cycle handshake; `inflight` is `gb_ren` from the previous cycle.
  - This credit rule prevents overflow and sustains 1 line/cycle when `out_ready` is held high.
- Address: `gb_raddr = base + issued` modulo 2^AW, so it wraps from all-ones to 0. `issued` increments on each `gb_ren`.
- Capture: one cycle after `gb_ren`, `gb_dout` is pushed into the FIFO. Push and pop in the same cycle are both honoured.
- Output:
  - `out_valid = (fifo_count != 0)`; `out_data` is the FIFO head.
  - `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
  - `out_last = out_valid && (sent == n_lines-1)`.
- `start` in RUN or FINISH is ignored; the latched parameters do not change.
- `gb_ren` is never asserted outside RUN.

## Timing
- Reset values (asynchronous, immediate on `rstn=0`): state IDLE; `gb_ren`, `out_valid`, `out_last`, `busy`, `done` all 0; `gb_raddr` 0; counters 0; FIFO empty.
- Reset mid-readback aborts: in-flight data is discarded and no `done` is produced.
- Latency, with `start` in cycle 0:
  - cycle 1: `busy=1`, `gb_ren=1`, `gb_raddr=base`;
  - cycle 2: `gb_dout` captured;
  - cycle 3: `out_valid=1`.
- Throughput: with `out_ready` held high, beats occur on consecutive cycles. The last beat is in cycle `n_lines+2` and `done` in cycle `n_lines+3`.
- `n_lines==0`: `done` pulses in cycle 1; `busy`, `gb_ren` and `out_valid` never assert.
- Backpressure: with `out_ready=0`, at most `FIFO_DEPTH` lines are buffered, after which `gb_ren` stays low. Reads resume so that no bubble is added beyond the stall itself.
- `done` rises the cycle after the last handshake; `busy` falls in that same cycle.

## Test plan
- Basic stream: preload lines 0x10000..0x1000F with pattern `addr`, `base=0x10000`, `n_lines=16`, `out_ready=1`:
  - expect 16 consecutive beats in order, starting in cycle 3;
  - `out_last` only on beat 15; `done` exactly once, in cycle 19.
- Backpressure: `n_lines=8`, toggle `out_ready` pseudo-randomly (seed fixed), including 20-cycle stalls:
  - data is in order with no loss or duplication;
  - FIFO never exceeds 2; `out_data` is stable during stalls; `gb_ren` is never high when credit is 0.
- Wrap-around: `base=0x1FFFE`, `n_lines=4` → `gb_raddr` sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001; data matches those lines.
- Zero length / ignored start:
  - `n_lines=0` → `done` in cycle 1, no beats.
  - `start` re-pulsed mid-RUN with a different `base_addr` → the original transfer completes unchanged.
- Reset mid-operation: `n_lines=64`, assert `rstn=0` after 10 beats:
  - all outputs 0 asynchronously, no `done`;
  - a new `start` after release streams correctly from the new `base`.
- Full layer: `n_lines=4096` (1024 samples × 64 features / 16) from 0x10000, `out_ready=1` → 4096 beats in 4096 consecutive cycles, checksum matches the reference model.
